// File: rtl/sb_tx_arbiter_if.sv
// Message type shared by the LTSM substates and the sideband TX, plus the
// bundle of request/response and TX-port signals around the arbiter.
package sb_tx_arbiter_pkg;
  typedef logic [7:0] SB_msg_t;
endpackage

interface sb_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  // Requester side
  logic [N_REQ-1:0]                            req_i;
  sb_tx_arbiter_pkg::SB_msg_t [N_REQ-1:0]      req_msg_i;
  logic [N_REQ-1:0][63:0]                      req_data_i;
  logic [N_REQ-1:0]                            ack_o;
  logic [N_REQ-1:0]                            timeout_o;
  logic [N_REQ-1:0]                            grant_o;
  // Sideband TX side
  sb_tx_arbiter_pkg::SB_msg_t                  SB_TX_msg_o;
  logic [63:0]                                 SB_TX_dataBus_o;
  logic                                        SB_TX_msg_valid_o;
  logic                                        SB_TX_msg_sendNextFlag_i;

  modport master (
    input  req_i, req_msg_i, req_data_i, SB_TX_msg_sendNextFlag_i,
    output ack_o, timeout_o, grant_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o
  );

  modport slave (
    output req_i, req_msg_i, req_data_i, SB_TX_msg_sendNextFlag_i,
    input  ack_o, timeout_o, grant_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o
  );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX message port between LTSM
// substates; the granted message is snapshotted and held until accepted or timed out.
module sb_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  enable_i,
  sb_tx_arbiter_if.master       bus
);
  import sb_tx_arbiter_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, owner_q, win_idx, next_ptr;
  logic [N_REQ-1:0]   grant_q, timeout_q;
  logic [TMR_W-1:0]   timer_q;
  SB_msg_t            msg_q;
  logic [63:0]        data_q;
  logic               win_found, accept, expire, load, release_msg;

  function automatic logic [PTR_W-1:0] wrap_add(logic [PTR_W-1:0] base, int offs);
    int sum = int'(base) + offs;
    return PTR_W'(sum % N_REQ);
  endfunction

  // First requester at or after the rr pointer, wrapping modulo N_REQ.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && bus.req_i[wrap_add(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  assign next_ptr = wrap_add(owner_q, 1);
  assign accept   = (state_q == SEND) && bus.SB_TX_msg_sendNextFlag_i;

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    release_msg = 1'b0;
    expire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && win_found) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Acceptance wins over a timeout landing in the same cycle.
        if (accept) begin
          release_msg = 1'b1;
          state_d     = IDLE;
        end else if (timer_q == TMR_LAST) begin
          expire      = 1'b1;
          release_msg = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      timeout_q <= '0;
      timer_q   <= '0;
      msg_q     <= '0;
      data_q    <= '0;
    end else begin
      timeout_q <= expire ? grant_q : '0;
      if (load) begin
        owner_q <= win_idx;
        grant_q <= N_REQ'(1) << win_idx;
        msg_q   <= bus.req_msg_i[win_idx];
        data_q  <= bus.req_data_i[win_idx];
        timer_q <= '0;
      end else if (release_msg) begin
        grant_q <= '0;
        ptr_q   <= next_ptr;
      end else if (state_q == SEND && timer_q != TMR_LAST) begin
        timer_q <= timer_q + TMR_W'(1);
      end
    end
  end

  // A reset cycle abandons the message, so no ack may escape during it.
  assign bus.ack_o             = (accept && !reset) ? grant_q : '0;
  assign bus.timeout_o         = timeout_q;
  assign bus.grant_o           = grant_q;
  assign bus.SB_TX_msg_o       = msg_q;
  assign bus.SB_TX_dataBus_o   = data_q;
  assign bus.SB_TX_msg_valid_o = (state_q == SEND);

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Self-checking bench for sb_tx_arbiter: a cycle-level reference model feeds
// scoreboard queues that an independent monitor drains against the DUT.
module tb_sb_tx_arbiter;
  import sb_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  sb_tx_arbiter_if #(.N_REQ(N)) bus();

  sb_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .enable_i   (enable),
    .bus        (bus)
  );

  typedef struct {
    logic [N-1:0] grant;
    SB_msg_t      msg;
    logic [63:0]  data;
  } cyc_exp_t;

  typedef struct {
    int cyc;
    bit is_to;
    int idx;
  } evt_t;

  cyc_exp_t     cyc_q[$];
  evt_t         evt_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cycle_no = 0;
  bit           mon_en = 1'b0;
  logic [N-1:0] resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle_no, act, exp);
    end
  endtask

  // Reference model: owner/pointer bookkeeping straight from the arbitration rules.
  int          m_ptr = 0;
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  int          m_wait = 0;
  SB_msg_t     m_msg = '0;
  logic [63:0] m_data = '0;
  bit          m_to_pend = 1'b0;
  int          m_to_idx = 0;

  always @(negedge clk) begin
    cyc_exp_t e;
    evt_t     ev;
    int       c;
    if (mon_en) begin
      cycle_no++;
      e.grant = m_busy ? (N'(1) << m_owner) : '0;
      e.msg   = m_msg;
      e.data  = m_data;
      cyc_q.push_back(e);
      if (m_to_pend) begin
        ev.cyc = cycle_no; ev.is_to = 1'b1; ev.idx = m_to_idx;
        evt_q.push_back(ev);
        m_to_pend = 1'b0;
      end
      if (reset) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else if (!m_busy) begin
        if (enable && bus.req_i != '0) begin
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (bus.req_i[c]) begin
              m_owner = c;
              break;
            end
          end
          m_busy = 1'b1;
          m_wait = 0;
          m_msg  = bus.req_msg_i[m_owner];
          m_data = bus.req_data_i[m_owner];
        end
      end else begin
        m_wait++;
        if (bus.SB_TX_msg_sendNextFlag_i) begin
          ev.cyc = cycle_no; ev.is_to = 1'b0; ev.idx = m_owner;
          evt_q.push_back(ev);
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end else if (m_wait == TO) begin
          m_to_pend = 1'b1;
          m_to_idx  = m_owner;
          m_busy    = 1'b0;
          m_ptr     = (m_owner + 1) % N;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against whatever the model queued.
  always @(negedge clk) begin
    cyc_exp_t     e;
    evt_t         ev;
    logic [N-1:0] pulses;
    #1;
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        check("cycle_queue_empty", 64'(cyc_q.size()), 64'd1);
      end else begin
        e = cyc_q.pop_front();
        check("grant", 64'(bus.grant_o), 64'(e.grant));
        check("valid", 64'(bus.SB_TX_msg_valid_o), 64'(|e.grant));
        if (e.grant != '0) begin
          check("tx_msg", 64'(bus.SB_TX_msg_o), 64'(e.msg));
          check("tx_data", bus.SB_TX_dataBus_o, e.data);
        end
      end
      while (evt_q.size() > 0 && evt_q[0].cyc < cycle_no) begin
        ev = evt_q.pop_front();
        check("missed_pulse_cycle", 64'(cycle_no), 64'(ev.cyc));
      end
      pulses = bus.ack_o | bus.timeout_o;
      if (pulses != '0) begin
        if (evt_q.size() == 0) begin
          check("unexpected_pulse", 64'(pulses), 64'd0);
        end else begin
          ev = evt_q.pop_front();
          check("pulse_cycle", 64'(cycle_no), 64'(ev.cyc));
          check("ack_timeout_bits", 64'({bus.ack_o, bus.timeout_o}),
                ev.is_to ? 64'({N'(0), N'(1) << ev.idx}) : 64'({N'(1) << ev.idx, N'(0)}));
        end
      end
    end
  end

  // One clock of stimulus; requesters drop req_i the cycle after their ack/timeout.
  task automatic cyc();
    @(negedge clk);
    #2;
    resp = bus.ack_o | bus.timeout_o;
    @(posedge clk);
    #1;
    bus.req_i = bus.req_i & ~resp;
  endtask

  task automatic auto_req(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!bus.req_i[i] && !resp[i] && $urandom_range(99) < pct) begin
        bus.req_i[i]      = 1'b1;
        bus.req_msg_i[i]  = SB_msg_t'($urandom);
        bus.req_data_i[i] = {$urandom, $urandom};
      end
    end
  endtask

  task automatic drain();
    bus.req_i = '0;
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    repeat (3) cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall;
    resp = '0;
    bus.req_i = '0;
    bus.req_msg_i = '0;
    bus.req_data_i = '0;
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // Single request, accepted on the third cycle of the message.
    enable = 1'b1;
    bus.req_msg_i[0]  = 8'hA5;
    bus.req_data_i[0] = 64'h1234;
    bus.req_i = 4'b0001;
    cyc();
    cyc();
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    cyc();
    cyc();

    // Snapshot: requester 2 changes its inputs while the TX stalls.
    bus.req_msg_i[2]  = 8'h3C;
    bus.req_data_i[2] = 64'hDEAD_BEEF_0000_0002;
    bus.req_i = 4'b0100;
    cyc();
    repeat (5) begin
      bus.req_msg_i[2]  = SB_msg_t'($urandom);
      bus.req_data_i[2] = {$urandom, $urandom};
      cyc();
    end
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    drain();

    // Timeout after exactly TO cycles of valid.
    bus.req_i = 4'b0010;
    cyc();
    repeat (TO + 1) cyc();
    drain();

    // Acceptance in the last waiting cycle beats the timeout.
    bus.req_i = 4'b0001;
    cyc();
    repeat (TO - 1) cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    drain();

    // Enable gating.
    enable = 1'b0;
    bus.req_i = 4'b0011;
    repeat (4) cyc();
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    cyc();
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    bus.req_i = 4'b0011;
    cyc();
    enable = 1'b1;
    cyc();
    drain();

    // Reset in the middle of a message.
    bus.req_i = 4'b1000;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.req_i = 4'b1111;
    cyc();
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    cyc();
    drain();

    // Round-robin with everyone requesting.
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    repeat (14) begin
      auto_req(100);
      cyc();
    end
    drain();

    // Randomized traffic with stall bursts long enough to hit timeouts.
    stall = 0;
    repeat (3000) begin
      enable = ($urandom_range(9) != 0);
      reset  = ($urandom_range(499) == 0);
      if (stall > 0) stall--;
      else if ($urandom_range(59) == 0) stall = $urandom_range(TO + 4, TO - 2);
      bus.SB_TX_msg_sendNextFlag_i = (stall == 0) && ($urandom_range(2) == 0);
      auto_req(30);
      cyc();
    end
    reset = 1'b0;
    enable = 1'b1;
    drain();
    repeat (2) cyc();

    mon_en = 1'b0;
    #20;
    check("events_drained", 64'(evt_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
